// File: rtl/mem_fill_verify_if.sv
// mem_fill_verify_if
//   Bundles the control handshake and the RAM bus of the fill/verify
//   controller so that one interface instance carries them.
//   Ports (signals):
//     start, abort, mode[1:0], seed[DATA_W], verify_en  - control towards the controller
//     busy, done, pass, err_count[ADDR_W+1], first_err_addr[ADDR_W] - status from it
//     add[ADDR_W], wr, wdata[DATA_W]                    - RAM request from the controller
//     rdata[DATA_W]                                     - RAM read data towards it
//   Modports:
//     master - the controller side
//     slave  - the environment side (top level logic plus RAM)
interface mem_fill_verify_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic              verify_en;
  logic [ADDR_W-1:0] add;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;

  modport master (
    input  start, abort, mode, seed, verify_en, rdata,
    output add, wr, wdata, busy, done, pass, err_count, first_err_addr
  );

  modport slave (
    output start, abort, mode, seed, verify_en, rdata,
    input  add, wr, wdata, busy, done, pass, err_count, first_err_addr
  );
endinterface

// File: rtl/mem_fill_verify.sv
// mem_fill_verify
//   Fills every word of a DEPTH x DATA_W single-port synchronous RAM with a
//   mode-selected pattern and optionally reads it all back, counting
//   mismatches and remembering the first failing address.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-low reset
//     bus  - mem_fill_verify_if.master: start/abort/mode/seed/verify_en in,
//            add/wr/wdata out to the RAM, rdata in from the RAM,
//            busy/done/pass/err_count/first_err_addr status out
module mem_fill_verify #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  mem_fill_verify_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Pattern word for address a under mode m and seed s, modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] a_ext;
    logic [DATA_W-1:0] r;
    a_ext = DATA_W'(a);
    case (m)
      2'd0:    r = s + a_ext;
      2'd1:    r = s;
      2'd2:    r = ~(s + a_ext);
      default: r = a[0] ? ~s : s;
    endcase
    return r;
  endfunction

  state_t            state, state_n;
  logic [ADDR_W-1:0] add_q, add_n;
  logic              wr_q, wr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [1:0]        mode_q, mode_n;
  logic [DATA_W-1:0] seed_q, seed_n;
  logic              verify_q, verify_n;
  logic              chk_valid, chk_valid_n;
  logic [ADDR_W-1:0] chk_addr, chk_addr_n;
  logic              pass_q, pass_n;
  logic [ADDR_W:0]   err_q, err_n;
  logic [ADDR_W-1:0] first_q, first_n;
  logic [ADDR_W-1:0] add_inc;
  logic              mismatch;

  assign add_inc = add_q + 1'b1;

  // The read issued last cycle returns now; chk_addr remembers which word it was.
  assign mismatch = chk_valid && (bus.rdata != pattern(mode_q, seed_q, chk_addr));

  // State and every output are registered here; only the comb block below
  // decides their next values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      add_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      verify_q  <= 1'b0;
      chk_valid <= 1'b0;
      chk_addr  <= '0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state     <= state_n;
      add_q     <= add_n;
      wr_q      <= wr_n;
      wdata_q   <= wdata_n;
      mode_q    <= mode_n;
      seed_q    <= seed_n;
      verify_q  <= verify_n;
      chk_valid <= chk_valid_n;
      chk_addr  <= chk_addr_n;
      pass_q    <= pass_n;
      err_q     <= err_n;
      first_q   <= first_n;
    end
  end

  // Next-state and next-output logic. wdata for address 0 is produced from
  // the incoming mode/seed at the accepting edge, since the latched copies
  // only become visible one cycle later.
  always_comb begin
    state_n     = state;
    add_n       = add_q;
    wr_n        = 1'b0;
    wdata_n     = wdata_q;
    mode_n      = mode_q;
    seed_n      = seed_q;
    verify_n    = verify_q;
    chk_valid_n = 1'b0;
    chk_addr_n  = add_q;
    pass_n      = pass_q;
    err_n       = err_q;
    first_n     = first_q;

    if (mismatch) begin
      err_n = err_q + 1'b1;
      if (err_q == '0) begin
        first_n = chk_addr;
      end
    end

    case (state)
      IDLE: begin
        add_n = '0;
        if (bus.start) begin
          mode_n   = bus.mode;
          seed_n   = bus.seed;
          verify_n = bus.verify_en;
          pass_n   = 1'b0;
          err_n    = '0;
          first_n  = '0;
          wr_n     = 1'b1;
          wdata_n  = pattern(bus.mode, bus.seed, '0);
          state_n  = WRITE;
        end
      end
      WRITE: begin
        if (bus.abort) begin
          add_n   = '0;
          pass_n  = 1'b0;
          state_n = IDLE;
        end else if (add_q == LAST_ADDR) begin
          add_n   = '0;
          state_n = verify_q ? READ : DONE;
        end else begin
          add_n   = add_inc;
          wr_n    = 1'b1;
          wdata_n = pattern(mode_q, seed_q, add_inc);
        end
      end
      READ: begin
        if (bus.abort) begin
          add_n   = '0;
          pass_n  = 1'b0;
          state_n = IDLE;
        end else begin
          chk_valid_n = 1'b1;
          if (add_q == LAST_ADDR) begin
            add_n   = '0;
            state_n = DRAIN;
          end else begin
            add_n = add_inc;
          end
        end
      end
      DRAIN: begin
        add_n = '0;
        if (bus.abort) begin
          pass_n  = 1'b0;
          state_n = IDLE;
        end else begin
          // err_n already includes the final word's compare.
          pass_n  = verify_q && (err_n == '0);
          state_n = DONE;
        end
      end
      DONE: begin
        add_n   = '0;
        state_n = IDLE;
      end
      default: begin
        add_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.add            = add_q;
  assign bus.wr             = wr_q;
  assign bus.wdata          = wdata_q;
  assign bus.busy           = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign bus.done           = (state == DONE);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_addr = first_q;

endmodule

// File: tb/tb_mem_fill_verify.sv
// tb_mem_fill_verify
//   Directed bench for mem_fill_verify: a default 8x8 instance and a 5x4
//   instance, each with a behavioural synchronous RAM. Edge E0 is the rising
//   edge that samples start; "window k" is the low phase after edge Ek.
module tb_mem_fill_verify;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_fill_verify_if #(.DATA_W(8), .ADDR_W(3)) if8 ();
  mem_fill_verify_if #(.DATA_W(4), .ADDR_W(3)) if5 ();

  mem_fill_verify u8 (.clk(clk), .rst(rst), .bus(if8));
  mem_fill_verify #(.DATA_W(4), .DEPTH(5)) u5 (.clk(clk), .rst(rst), .bus(if5));

  logic [7:0] mem8 [8];
  logic [3:0] mem5 [5];
  logic       clr     = 1'b0;
  logic       flip_en = 1'b0;
  int         done8;
  int         done5;
  logic [2:0] max5;

  // RAM models plus done-pulse counters and the highest address the small
  // instance ever presents. Reads of addresses 5/6 can be corrupted in bit 0.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) mem8[i] <= 8'hEE;
      for (int i = 0; i < 5; i++) mem5[i] <= 4'hE;
      done8 <= 0;
      done5 <= 0;
      max5  <= 3'd0;
    end else begin
      if (if8.wr) mem8[if8.add] <= if8.wdata;
      if (if5.wr && if5.add < 3'd5) mem5[if5.add] <= if5.wdata;
      if (if8.done) done8 <= done8 + 1;
      if (if5.done) done5 <= done5 + 1;
      if (if5.add > max5) max5 <= if5.add;
    end
    if8.rdata <= mem8[if8.add] ^
                 ((flip_en && !if8.wr && (if8.add == 3'd5 || if8.add == 3'd6)) ? 8'h01 : 8'h00);
    if5.rdata <= (if5.add < 3'd5) ? mem5[if5.add] : 4'h0;
  end

  task automatic clear_models();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Leaves the bench in window 0 of the new run.
  task automatic start8(input logic [1:0] m, input logic [7:0] s, input logic v);
    @(negedge clk);
    if8.start     = 1'b1;
    if8.mode      = m;
    if8.seed      = s;
    if8.verify_en = v;
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic wait_done8(input int k0, output int k);
    k = k0;
    while (if8.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if8.add, if8.wr, if8.wdata, if8.busy, if8.done, if8.pass} !== 14'h0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl8: got %h required 0",
               {if8.add, if8.wr, if8.wdata, if8.busy, if8.done, if8.pass});
    end
    checks++;
    if ({if8.err_count, if8.first_err_addr} !== 7'h0) begin
      errors++;
      $display("[TB] FAIL reset_stat8: got %h required 0", {if8.err_count, if8.first_err_addr});
    end
    checks++;
    if ({if5.add, if5.wr, if5.wdata, if5.busy, if5.done, if5.pass, if5.err_count} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_all5: got %h required 0",
               {if5.add, if5.wr, if5.wdata, if5.busy, if5.done, if5.pass, if5.err_count});
    end
    rst = 1'b1;
  endtask

  task automatic test_fill_verify();
    int k;
    clear_models();
    start8(2'd0, 8'h10, 1'b1);
    wait_done8(0, k);
    checks++;
    if (k !== 17) begin
      errors++;
      $display("[TB] FAIL fv_done_edge: got %0d required 17", k);
    end
    checks++;
    if ({if8.pass, if8.err_count, if8.first_err_addr} !== {1'b1, 4'd0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL fv_status: got %h required %h",
               {if8.pass, if8.err_count, if8.first_err_addr}, {1'b1, 4'd0, 3'd0});
    end
    for (int a = 0; a < 8; a++) begin
      checks++;
      if (mem8[a] !== 8'h10 + 8'(a)) begin
        errors++;
        $display("[TB] FAIL fv_mem[%0d]: got %h required %h", a, mem8[a], 8'h10 + 8'(a));
      end
    end
    @(negedge clk);
    checks++;
    if ({if8.done, if8.busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fv_done_width: got done/busy %b required 00", {if8.done, if8.busy});
    end
  endtask

  task automatic test_verify_errors();
    int k;
    clear_models();
    flip_en = 1'b1;
    start8(2'd0, 8'h10, 1'b1);
    wait_done8(0, k);
    checks++;
    if (k !== 17) begin
      errors++;
      $display("[TB] FAIL ve_done_edge: got %0d required 17", k);
    end
    repeat (3) @(negedge clk);
    flip_en = 1'b0;
    checks++;
    if ({if8.pass, if8.err_count, if8.first_err_addr} !== {1'b0, 4'd2, 3'd5}) begin
      errors++;
      $display("[TB] FAIL ve_status: got %h required %h",
               {if8.pass, if8.err_count, if8.first_err_addr}, {1'b0, 4'd2, 3'd5});
    end
  endtask

  task automatic test_small_no_verify();
    int k;
    clear_models();
    @(negedge clk);
    if5.start     = 1'b1;
    if5.mode      = 2'd3;
    if5.seed      = 4'hA;
    if5.verify_en = 1'b0;
    @(negedge clk);
    if5.start = 1'b0;
    k = 0;
    while (if5.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 5) begin
      errors++;
      $display("[TB] FAIL small_done_edge: got %0d required 5", k);
    end
    checks++;
    if ({if5.pass, if5.err_count} !== 5'h0) begin
      errors++;
      $display("[TB] FAIL small_status: got %h required 0", {if5.pass, if5.err_count});
    end
    repeat (4) @(negedge clk);
    for (int a = 0; a < 5; a++) begin
      checks++;
      if (mem5[a] !== ((a % 2 == 0) ? 4'hA : 4'h5)) begin
        errors++;
        $display("[TB] FAIL small_mem[%0d]: got %h required %h", a, mem5[a],
                 (a % 2 == 0) ? 4'hA : 4'h5);
      end
    end
    checks++;
    if (max5 !== 3'd4 || done5 !== 1) begin
      errors++;
      $display("[TB] FAIL small_range: got max add %0d done pulses %0d required 4 and 1", max5, done5);
    end
  endtask

  task automatic test_start_ignored();
    int k;
    logic [7:0] exp;
    clear_models();
    start8(2'd2, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    if8.start = 1'b1;
    if8.mode  = 2'd0;
    if8.seed  = 8'h55;
    @(negedge clk);
    if8.start = 1'b0;
    wait_done8(4, k);
    checks++;
    if (k !== 17 || if8.pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL si_done: got edge %0d pass %b required 17 and 1", k, if8.pass);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done8 !== 1) begin
      errors++;
      $display("[TB] FAIL si_done_pulses: got %0d required 1", done8);
    end
    for (int a = 0; a < 8; a++) begin
      exp = ~(8'hFF + 8'(a));
      checks++;
      if (mem8[a] !== exp) begin
        errors++;
        $display("[TB] FAIL si_mem[%0d]: got %h required %h", a, mem8[a], exp);
      end
    end
  endtask

  task automatic test_abort_read();
    int   k;
    logic bad;
    clear_models();
    start8(2'd0, 8'h20, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if ({if8.busy, if8.wr, if8.add} !== {1'b1, 1'b0, 3'd2}) begin
      errors++;
      $display("[TB] FAIL ab_in_read: got %b required 102", {if8.busy, if8.wr, if8.add});
    end
    if8.abort = 1'b1;
    @(negedge clk);
    if8.abort = 1'b0;
    checks++;
    if ({if8.busy, if8.wr, if8.done, if8.pass, if8.add} !== 7'h0) begin
      errors++;
      $display("[TB] FAIL ab_idle: got %b required 0", {if8.busy, if8.wr, if8.done, if8.pass, if8.add});
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if8.wr !== 1'b0 || if8.done !== 1'b0 || if8.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || done8 !== 0) begin
      errors++;
      $display("[TB] FAIL ab_quiet: got activity %b done pulses %0d required 0 and 0", bad, done8);
    end
    start8(2'd1, 8'h3C, 1'b1);
    wait_done8(0, k);
    checks++;
    if ({k[7:0], if8.pass, if8.err_count} !== {8'd17, 1'b1, 4'd0}) begin
      errors++;
      $display("[TB] FAIL ab_rerun: got edge %0d pass %b err %0d required 17 1 0", k, if8.pass, if8.err_count);
    end
    checks++;
    if ({mem8[0], mem8[3], mem8[7]} !== {3{8'h3C}}) begin
      errors++;
      $display("[TB] FAIL ab_rerun_mem: got %h required 3c3c3c", {mem8[0], mem8[3], mem8[7]});
    end
  endtask

  task automatic test_reset_mid_write();
    int k;
    clear_models();
    start8(2'd0, 8'h40, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({if8.add, if8.wr, if8.wdata, if8.busy, if8.done, if8.pass, if8.err_count, if8.first_err_addr}
        !== 21'h0) begin
      errors++;
      $display("[TB] FAIL rmw_outputs: got %h required 0",
               {if8.add, if8.wr, if8.wdata, if8.busy, if8.done, if8.pass, if8.err_count, if8.first_err_addr});
    end
    rst = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    if (done8 !== 0 || if8.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmw_stays_idle: got done pulses %0d busy %b required 0 0", done8, if8.busy);
    end
    start8(2'd0, 8'h01, 1'b0);
    wait_done8(0, k);
    checks++;
    if (k !== 8 || if8.pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmw_rerun: got edge %0d pass %b required 8 0", k, if8.pass);
    end
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      checks++;
      if (mem8[a] !== 8'h01 + 8'(a)) begin
        errors++;
        $display("[TB] FAIL rmw_mem[%0d]: got %h required %h", a, mem8[a], 8'h01 + 8'(a));
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_models();
    @(negedge clk);
    if8.start     = 1'b1;
    if8.abort     = 1'b1;
    if8.mode      = 2'd0;
    if8.seed      = 8'h70;
    if8.verify_en = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    if8.abort = 1'b0;
    checks++;
    if (if8.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bb_start_wins: got busy %b required 1", if8.busy);
    end
    wait_done8(0, k);
    checks++;
    if (k !== 8) begin
      errors++;
      $display("[TB] FAIL bb_done_edge: got %0d required 8", k);
    end
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({if8.busy, if8.done, if8.wr} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL bb_start_in_done: got busy/done/wr %b required 000", {if8.busy, if8.done, if8.wr});
    end
    checks++;
    if ({mem8[0], mem8[7]} !== {8'h70, 8'h77}) begin
      errors++;
      $display("[TB] FAIL bb_mem: got %h required 7077", {mem8[0], mem8[7]});
    end
  endtask

  initial begin
    if8.start = 1'b0; if8.abort = 1'b0; if8.mode = 2'd0; if8.seed = 8'h00; if8.verify_en = 1'b0;
    if5.start = 1'b0; if5.abort = 1'b0; if5.mode = 2'd0; if5.seed = 4'h0; if5.verify_en = 1'b0;
    test_reset();
    test_fill_verify();
    test_verify_errors();
    test_small_no_verify();
    test_start_ignored();
    test_abort_read();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fill_verify.md
Name: mem_fill_verify

Overview:
- Parametrised successor to the fixed 8-entry × 8-bit RAM-fill controller.
- On start, writes a mode-selected data pattern to every location of an external single-port synchronous RAM of DEPTH × DATA_W.
- Optionally reads every location back and compares it against the same pattern, reporting pass/fail, error count and first failing address.
- Sits between the top-level start/done handshake and the RAM instance, in place of the old controller.

Parameters:
- DATA_W, 8, data bus width (≥2)
- DEPTH, 8, number of RAM words (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- abort  in  1  cancel current operation; sampled in WRITE/READ/DRAIN
- mode  in  2  pattern select; latched at start
- seed  in  DATA_W  pattern seed; latched at start
- verify_en  in  1  1 = read back and check after fill; latched at start
- add  out  ADDR_W  RAM address
- wr  out  1  RAM write enable
- wdata  out  DATA_W  RAM write data
- rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented with wr=0
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  one-cycle completion pulse
- pass  out  1  last verify completed with zero errors
- err_count  out  ADDR_W+1  mismatches in last verify
- first_err_addr  out  ADDR_W  address of first mismatch in last verify

Behaviour:
- Reset (rst=0 at a rising edge, from any state including mid-operation):
  - state = IDLE.
  - add, wr, wdata, busy, done, pass, err_count, first_err_addr all 0.
  - Latched mode/seed/verify_en cleared.
- Pattern P(a) for address a, with S = latched seed and arithmetic mod 2^DATA_W:
  - mode 0: S + a
  - mode 1: S
  - mode 2: ~(S + a)
  - mode 3: S if a even, ~S if a odd
- States:
  - IDLE: wr=0, add=0. On start=1:
    - latch mode, seed and verify_en;
    - clear pass, err_count and first_err_addr;
    - go to WRITE. Call the sampling edge E0.
  - WRITE: wr=1, wdata=P(add). add runs 0..DEPTH-1, incrementing one per cycle.
    - After the write at DEPTH-1: add returns to 0, then go to READ if verify_en else DONE.
  - READ: wr=0. add runs 0..DEPTH-1, one per cycle.
    - A registered compare pipeline checks rdata against P(add of the previous cycle) on the following cycle.
    - After issuing DEPTH-1, go to DRAIN.
  - DRAIN: one cycle; compares the last word. Then go to DONE.
  - DONE: done=1 for exactly one cycle.
    - pass = (verify_en && err_count==0), registered on entry to DONE.
    - Then go to IDLE.
- Latency:
  - With verify: done high between edges E(2·DEPTH+1) and E(2·DEPTH+2).
  - Without verify: done high between E(DEPTH) and E(DEPTH+1).
- Mismatch handling:
  - Each mismatch increments err_count. It cannot overflow, since the maximum is DEPTH.
  - The first mismatch (err_count was 0) captures its address into first_err_addr.
  - first_err_addr stays 0 if there are no errors.
- Hold behaviour: err_count, first_err_addr and pass hold their values until the next accepted start or reset.
- start while busy: ignored. A start asserted during DONE is also ignored; it must be sampled in IDLE.
- abort=1 in WRITE, READ or DRAIN:
  - next state IDLE; wr=0 from the next cycle;
  - done is not pulsed; pass=0;
  - err_count and first_err_addr keep their partial values.
- abort in IDLE/DONE: no effect. abort and start together in IDLE: start wins.
- Address wrap: add never exceeds DEPTH-1 and returns to 0 at the end of each pass. A non-power-of-two DEPTH must not touch addresses ≥ DEPTH.
- Outputs add, wr and wdata are registered; no combinational path from any input to any output.

Test Plan:
- Default params, mode 0, seed 8'h10, verify_en=1, ideal RAM model → writes 10..17 at addresses 0..7; done at edge E17; pass=1; err_count=0.
- Same, but the bench flips rdata bit 0 on reads of addresses 5 and 6 → err_count=2, first_err_addr=5, pass=0, done still at E17.
- DEPTH=5, DATA_W=4, mode 3, seed 4'hA, verify_en=0 → writes A,5,A,5,A to addresses 0..4; never drives add>4; done at E5; pass=0.
- mode 2, seed 8'hFF, start pulsed again mid-WRITE → second start ignored; data 00,FF,FE,...,F9; exactly one done pulse.
- abort at cycle 3 of READ → IDLE next cycle; no done; busy=0; wr stays 0; a following start runs a full clean sequence.
- rst=0 for one cycle mid-WRITE → all outputs 0 at the next edge; state IDLE; a subsequent start behaves as from power-up.
